// File: rtl/panel_cfg_ctrl_if.sv
// Commit bus between the front-panel controller and the filter/wavegen
// configuration registers: valid/ready handshake plus the configuration payload.
interface panel_cfg_ctrl_if #(
  parameter int unsigned FREQ_W = 8
);
  logic              o_cfg_valid;
  logic              i_cfg_ready;
  logic [1:0]        o_wave;
  logic [1:0]        o_filt;
  logic [FREQ_W-1:0] o_freq;

  modport master (
    output o_cfg_valid, o_wave, o_filt, o_freq,
    input  i_cfg_ready
  );

  modport slave (
    input  o_cfg_valid, o_wave, o_filt, o_freq,
    output i_cfg_ready
  );
endinterface

// File: rtl/panel_cfg_ctrl.sv
// Front-panel controller: debounces four buttons, arbitrates press events and
// commits the shadow configuration. Build option: AUTO_REPEAT_EN (UP/DOWN auto-repeat).
module panel_cfg_ctrl #(
  parameter int unsigned DEB_CYCLES    = 1000,
  parameter int unsigned FREQ_W        = 8,
  parameter int unsigned FREQ_INIT     = 10,
  parameter int unsigned FREQ_MAX      = 200,
  parameter int unsigned REPEAT_CYCLES = 50000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [3:0]  i_btn,
  output logic        o_busy,
  panel_cfg_ctrl_if.master cfg
);

  localparam int unsigned NB    = 4;
  localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);

  localparam logic [1:0] S_INIT   = 2'd0;
  localparam logic [1:0] S_IDLE   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  logic [NB-1:0]     sync1_q, sync2_q;
  logic [NB-1:0]     deb_q, deb_d, deb_prev_q;
  logic [DEB_W-1:0]  cnt_q [NB];
  logic [DEB_W-1:0]  cnt_d [NB];
  logic [NB-1:0]     rise_c, press_d, press_q, win_d, win_q;
  logic [1:0]        state_q, state_d;
  logic [1:0]        wave_q, wave_d, filt_q, filt_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic              valid_q, busy_q;

  // Debounce: level follows the synchronized input only after DEB_CYCLES stable cycles
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_W'(DEB_CYCLES - 1)) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DEB_W'(1);
        end
      end
    end
  end

  assign rise_c = deb_q & ~deb_prev_q;

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RPT_W = $clog2(REPEAT_CYCLES + 1);

  logic [RPT_W-1:0] rpt_q [2];
  logic [RPT_W-1:0] rpt_d [2];
  logic [1:0]       rpt_fire_c;

  // UP/DOWN repeat timers restart on the press and run while the level stays high
  always_comb begin
    for (int j = 0; j < 2; j++) begin
      rpt_d[j]      = '0;
      rpt_fire_c[j] = 1'b0;
      if (deb_q[j+2] && !rise_c[j+2]) begin
        if (rpt_q[j] == RPT_W'(REPEAT_CYCLES - 1)) begin
          rpt_fire_c[j] = 1'b1;
        end else begin
          rpt_d[j] = rpt_q[j] + RPT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      rpt_q[0] <= '0;
      rpt_q[1] <= '0;
    end else begin
      rpt_q[0] <= rpt_d[0];
      rpt_q[1] <= rpt_d[1];
    end
  end

  assign press_d = rise_c | {rpt_fire_c, 2'b00};
`else
  assign press_d = rise_c;
`endif

  // Fixed priority WAVE > FILT > UP > DOWN; losers are discarded
  always_comb begin
    win_d = '0;
    if (press_q[0])      win_d[0] = 1'b1;
    else if (press_q[1]) win_d[1] = 1'b1;
    else if (press_q[2]) win_d[2] = 1'b1;
    else if (press_q[3]) win_d[3] = 1'b1;
  end

  // Configuration FSM; events reaching it outside IDLE are dropped
  always_comb begin
    state_d = state_q;
    wave_d  = wave_q;
    filt_d  = filt_q;
    freq_d  = freq_q;
    case (state_q)
      S_INIT: state_d = S_COMMIT;
      S_IDLE: begin
        if (win_q[0]) begin
          wave_d  = wave_q + 2'd1;
          state_d = S_COMMIT;
        end else if (win_q[1]) begin
          filt_d  = (filt_q == 2'd2) ? 2'd0 : filt_q + 2'd1;
          state_d = S_COMMIT;
        end else if (win_q[2] && freq_q != FREQ_W'(FREQ_MAX)) begin
          freq_d  = freq_q + FREQ_W'(1);
          state_d = S_COMMIT;
        end else if (win_q[3] && freq_q != FREQ_W'(1)) begin
          freq_d  = freq_q - FREQ_W'(1);
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: if (cfg.i_cfg_ready) state_d = S_IDLE;
      default:  state_d = S_INIT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
      press_q    <= '0;
      win_q      <= '0;
      state_q    <= S_INIT;
      wave_q     <= 2'd0;
      filt_q     <= 2'd0;
      freq_q     <= FREQ_W'(FREQ_INIT);
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sync1_q    <= i_btn;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
      press_q    <= press_d;
      win_q      <= win_d;
      state_q    <= state_d;
      wave_q     <= wave_d;
      filt_q     <= filt_d;
      freq_q     <= freq_d;
      valid_q    <= (state_d == S_COMMIT);
      busy_q     <= (state_d == S_COMMIT);
    end
  end

  assign cfg.o_cfg_valid = valid_q;
  assign cfg.o_wave      = wave_q;
  assign cfg.o_filt      = filt_q;
  assign cfg.o_freq      = freq_q;
  assign o_busy          = busy_q;

endmodule

// File: tb/tb_panel_cfg_ctrl.sv
// Bench for panel_cfg_ctrl: directed steps plus random presses against a
// press-level configuration model. Define AUTO_REPEAT_EN to match an auto-repeat build.
module tb_panel_cfg_ctrl;

  localparam int unsigned DEB   = 4;
  localparam int unsigned FINIT = 10;
  localparam int unsigned FMAX  = 12;
  localparam int unsigned RPT   = 20;
  localparam int unsigned FW    = 8;
  // Raw rise is set just before tick 1 (edge k); valid shows up at edge k+DEB+4
  localparam int LAT = DEB + 5;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [3:0] i_btn;
  logic       o_busy;

  panel_cfg_ctrl_if #(.FREQ_W(FW)) cfg ();

  panel_cfg_ctrl #(
    .DEB_CYCLES   (DEB),
    .FREQ_W       (FW),
    .FREQ_INIT    (FINIT),
    .FREQ_MAX     (FMAX),
    .REPEAT_CYCLES(RPT)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_btn (i_btn),
    .o_busy(o_busy),
    .cfg   (cfg)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int exp_wave, exp_filt, exp_freq;
  int n, seen;
  bit ch;
  int got_t[$];
  int got_f[$];
  int want_t[$];
  int want_f[$];

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_wave = 0;
    exp_filt = 0;
    exp_freq = FINIT;
  endtask

  // Effect of one press on the configuration; changed=0 means no commit
  task automatic model_event(input logic [3:0] m, output bit changed);
    changed = 1'b1;
    if (m[0])      exp_wave = (exp_wave + 1) % 4;
    else if (m[1]) exp_filt = (exp_filt + 1) % 3;
    else if (m[2]) begin
      if (exp_freq < int'(FMAX)) exp_freq++; else changed = 1'b0;
    end else if (m[3]) begin
      if (exp_freq > 1) exp_freq--; else changed = 1'b0;
    end else changed = 1'b0;
  endtask

  task automatic chk_cfg(input string tag);
    chk({tag, "_wave"}, 32'(cfg.o_wave), exp_wave);
    chk({tag, "_filt"}, 32'(cfg.o_filt), exp_filt);
    chk({tag, "_freq"}, 32'(cfg.o_freq), exp_freq);
  endtask

  // Press with ready held high: raw high through edges 1..hold
  task automatic press(input logic [3:0] m, input int hold, input string tag);
    bit c;
    int cnt, first;
    model_event(m, c);
    cnt = 0;
    first = -1;
    i_btn = m;
    for (int t = 1; t <= hold + int'(DEB) + 10; t++) begin
      tick();
      if (t == hold) i_btn = '0;
      if (cfg.o_cfg_valid === 1'b1) begin
        cnt++;
        if (first < 0) begin
          first = t;
          chk_cfg(tag);
          chk({tag, "_busy"}, 32'(o_busy), 1);
        end
      end
    end
    chk({tag, "_commits"}, cnt, c ? 1 : 0);
    if (c) chk({tag, "_latency"}, first, LAT);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    i_rst = 1'b0;
    i_btn = '0;
    cfg.i_cfg_ready = 1'b0;
    model_reset();
    repeat (3) tick();

    // Reset values
    chk("rst_valid", 32'(cfg.o_cfg_valid), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk_cfg("rst");

    // Exactly one INIT commit after reset release
    cfg.i_cfg_ready = 1'b1;
    i_rst = 1'b1;
    n = 0;
    seen = -1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (cfg.o_cfg_valid === 1'b1) begin
        n++;
        if (seen < 0) begin
          seen = t;
          chk_cfg("init");
        end
      end
    end
    chk("init_commits", n, 1);
    chk("init_rise_early", 32'(seen >= 1 && seen <= 2), 1);

    // WAVE four times wraps 1,2,3,0
    for (int i = 0; i < 4; i++) begin
      press(4'b0001, 10, "wave");
      chk("wave_seq", 32'(cfg.o_wave), (i + 1) % 4);
    end

    // Bounce shorter than the debounce window
    n = 0;
    begin
      logic [4:0] pat;
      pat = 5'b01101;
      for (int t = 0; t < 20; t++) begin
        i_btn = (t < 5) ? {1'b0, pat[t], 2'b00} : 4'b0000;
        tick();
        if (cfg.o_cfg_valid === 1'b1) n++;
      end
    end
    chk("bounce_commits", n, 0);
    chk_cfg("bounce");

    // WAVE and DOWN together: only WAVE wins
    press(4'b1001, 8, "wave_down");
    chk("wave_down_freq", 32'(cfg.o_freq), FINIT);

    // UP with a 30-cycle stall and a second press dropped while busy
    cfg.i_cfg_ready = 1'b0;
    model_event(4'b0100, ch);
    i_btn = 4'b0100;
    for (int t = 1; t <= LAT; t++) begin
      tick();
      if (t == 7) i_btn = '0;
    end
    chk("stall_rise", 32'(cfg.o_cfg_valid), 1);
    for (int s = 1; s <= 30; s++) begin
      tick();
      if (s == 8)  i_btn = 4'b0100;
      if (s == 16) i_btn = '0;
      chk("stall_valid", 32'(cfg.o_cfg_valid), 1);
      chk_cfg("stall");
    end
    cfg.i_cfg_ready = 1'b1;
    tick();
    chk("stall_drop", 32'(cfg.o_cfg_valid), 0);
    n = 0;
    for (int t = 0; t < 15; t++) begin
      tick();
      if (cfg.o_cfg_valid === 1'b1) n++;
    end
    chk("stall_press_dropped", n, 0);
    chk("stall_freq", 32'(cfg.o_freq), 11);
    press(4'b0100, 8, "up_to_max");
    chk("up_max_freq", 32'(cfg.o_freq), FMAX);
    press(4'b0100, 8, "up_sat");
    chk("up_sat_freq", 32'(cfg.o_freq), FMAX);

    // Random presses, including multi-button chords
    for (int r = 0; r < 14; r++) begin
      logic [3:0] m;
      int h;
      m = 4'($urandom_range(1, 15));
      h = int'($urandom_range(DEB + 3, 12));
      press(m, h, "rand");
    end

    // Reset in the middle of a stalled commit
    cfg.i_cfg_ready = 1'b0;
    ch = 1'b0;
    i_btn = 4'b0010;
    for (int t = 1; t <= 20 && !ch; t++) begin
      tick();
      if (t == 8) i_btn = '0;
      if (cfg.o_cfg_valid === 1'b1) ch = 1'b1;
    end
    chk("midrst_reached_commit", 32'(ch), 1);
    i_btn = '0;
    i_rst = 1'b0;
    model_reset();
    tick();
    chk("midrst_valid", 32'(cfg.o_cfg_valid), 0);
    chk("midrst_busy", 32'(o_busy), 0);
    chk_cfg("midrst");
    tick();
    cfg.i_cfg_ready = 1'b1;
    i_rst = 1'b1;
    n = 0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (cfg.o_cfg_valid === 1'b1) begin
        n++;
        chk_cfg("midrst_init");
      end
    end
    chk("midrst_init_commits", n, 1);

    // Hold DOWN long: one commit per press, plus repeats in an auto-repeat build
    want_t.delete();
    want_f.delete();
    got_t.delete();
    got_f.delete();
`ifdef AUTO_REPEAT_EN
    for (int j = 0; j < 4; j++) begin
      model_event(4'b1000, ch);
      if (ch) begin
        want_t.push_back(LAT + j * int'(RPT));
        want_f.push_back(exp_freq);
      end
    end
`else
    model_event(4'b1000, ch);
    want_t.push_back(LAT);
    want_f.push_back(exp_freq);
`endif
    i_btn = 4'b1000;
    for (int t = 1; t <= 95; t++) begin
      tick();
      if (t == 75) i_btn = '0;
      if (cfg.o_cfg_valid === 1'b1) begin
        got_t.push_back(t);
        got_f.push_back(32'(cfg.o_freq));
      end
    end
    chk("hold_down_commits", got_t.size(), want_t.size());
    for (int j = 0; j < want_t.size() && j < got_t.size(); j++) begin
      chk("hold_down_time", got_t[j], want_t[j]);
      chk("hold_down_freq", got_f[j], want_f[j]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
